// File: rtl/box_motion_ctrl.sv
// Frame-synchronous box motion scheduler: steps a box position with wall bounce once
// per FRAME_DIV frames and publishes it only at a frame boundary, with a host load override.
module box_motion_ctrl #(
  parameter int SCREEN_WIDTH   = 800,
  parameter int SCREEN_HEIGHT  = 600,
  parameter int BOX_W          = 32,
  parameter int BOX_H          = 32,
  parameter int X_INIT         = 250,
  parameter int Y_INIT         = 200,
  parameter int FRAME_DIV      = 1,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       vs,
  input  logic       enable,
  input  logic [3:0] speed_x,
  input  logic [3:0] speed_y,
  input  logic       load,
  input  logic [9:0] load_x,
  input  logic [9:0] load_y,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       update,
  output logic [1:0] bounce,
  output logic [1:0] state_dbg
);

  localparam logic [10:0] XMAX     = 11'(SCREEN_WIDTH - BOX_W);
  localparam logic [10:0] YMAX     = 11'(SCREEN_HEIGHT - BOX_H);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
  localparam logic [9:0]  X_RST    = 10'(X_INIT);
  localparam logic [9:0]  Y_RST    = 10'(Y_INIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [10:0] pos;
    logic        dir_pos;
    logic        hit;
  } axis_t;

  state_t state_q, state_d;

  logic vs_act, vs_s1, vs_s2, vs_d, frame_edge;
  logic [7:0] div_cnt;
  logic step_req;

  logic       pend;
  logic [9:0] pend_x, pend_y;

  logic [3:0]  spd_x, spd_y;
  logic        use_load;
  logic [10:0] sx, sy;
  logic        dir_x, dir_y, hit_x, hit_y;
  axis_t       nxt_x, nxt_y;

  // One axis of bounce motion; a zero speed leaves position and direction untouched.
  function automatic axis_t step_axis(input logic [10:0] pos, input logic [3:0] spd,
                                      input logic dir_pos, input logic [10:0] lim);
    axis_t r;
    logic [10:0] spd_w;
    spd_w     = {7'd0, spd};
    r.pos     = pos;
    r.dir_pos = dir_pos;
    r.hit     = 1'b0;
    if (spd != 4'd0) begin
      if (dir_pos) begin
        if (pos + spd_w >= lim) begin
          r.pos     = lim;
          r.dir_pos = 1'b0;
          r.hit     = 1'b1;
        end else begin
          r.pos = pos + spd_w;
        end
      end else begin
        if (pos <= spd_w) begin
          r.pos     = 11'd0;
          r.dir_pos = 1'b1;
          r.hit     = 1'b1;
        end else begin
          r.pos = pos - spd_w;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [10:0] lim);
    return ({1'b0, v} > lim) ? lim[9:0] : v;
  endfunction

  // Polarity is folded in before the synchronizer so its flops reset to "deasserted".
  assign vs_act     = VS_ACTIVE_HIGH ? vs : ~vs;
  assign frame_edge = vs_s2 & ~vs_d;
  assign state_dbg  = state_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_d  <= 1'b0;
    end else begin
      vs_s1 <= vs_act;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt  <= 8'd0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (frame_edge) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt  <= 8'd0;
          step_req <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

  // A load in the COMMIT cycle wins over the clear, so it survives to the next step.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pend   <= 1'b0;
      pend_x <= 10'd0;
      pend_y <= 10'd0;
    end else if (load) begin
      pend   <= 1'b1;
      pend_x <= load_x;
      pend_y <= load_y;
    end else if (state_q == COMMIT && use_load) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (step_req && (enable || pend)) state_d = STEP_X;
      STEP_X:  state_d = STEP_Y;
      STEP_Y:  state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign nxt_x = step_axis({1'b0, box_x}, spd_x, dir_x, XMAX);
  assign nxt_y = step_axis({1'b0, box_y}, spd_y, dir_y, YMAX);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      spd_x    <= 4'd0;
      spd_y    <= 4'd0;
      use_load <= 1'b0;
      sx       <= {1'b0, X_RST};
      sy       <= {1'b0, Y_RST};
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      hit_x    <= 1'b0;
      hit_y    <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == STEP_X) begin
        spd_x    <= speed_x;
        spd_y    <= speed_y;
        use_load <= pend;
      end
      if (state_q == STEP_X && !use_load) begin
        sx    <= nxt_x.pos;
        dir_x <= nxt_x.dir_pos;
        hit_x <= nxt_x.hit;
      end
      if (state_q == STEP_Y && !use_load) begin
        sy    <= nxt_y.pos;
        dir_y <= nxt_y.dir_pos;
        hit_y <= nxt_y.hit;
      end
    end
  end

  // The load path reads the pending registers at commit so the latest pre-commit load wins.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      box_x  <= X_RST;
      box_y  <= Y_RST;
      update <= 1'b0;
      bounce <= 2'b00;
    end else begin
      update <= 1'b0;
      if (state_q == COMMIT) begin
        update <= 1'b1;
        if (use_load) begin
          box_x  <= clamp(pend_x, XMAX);
          box_y  <= clamp(pend_y, YMAX);
          bounce <= 2'b00;
        end else begin
          box_x  <= sx[9:0];
          box_y  <= sy[9:0];
          bounce <= {hit_y, hit_x};
        end
      end
    end
  end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Bench for box_motion_ctrl: a FRAME_DIV=1 and a FRAME_DIV=4 instance share stimulus and
// are checked cycle by cycle against a frame-level reference model.
module tb_box_motion_ctrl;

  localparam int XMAX = 768;
  localparam int YMAX = 568;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       vs = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] speed_x = 4'd0;
  logic [3:0] speed_y = 4'd0;
  logic       load = 1'b0;
  logic [9:0] load_x = 10'd0;
  logic [9:0] load_y = 10'd0;

  logic [9:0] d1_box_x, d1_box_y, d4_box_x, d4_box_y;
  logic       d1_update, d4_update;
  logic [1:0] d1_bounce, d4_bounce, d1_state, d4_state;

  always #10 CLOCK_50 = ~CLOCK_50;

  box_motion_ctrl #(.FRAME_DIV(1)) dut1 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .vs(vs), .enable(enable),
    .speed_x(speed_x), .speed_y(speed_y), .load(load), .load_x(load_x), .load_y(load_y),
    .box_x(d1_box_x), .box_y(d1_box_y), .update(d1_update), .bounce(d1_bounce),
    .state_dbg(d1_state)
  );

  box_motion_ctrl #(.FRAME_DIV(4)) dut4 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .vs(vs), .enable(enable),
    .speed_x(speed_x), .speed_y(speed_y), .load(load), .load_x(load_x), .load_y(load_y),
    .box_x(d4_box_x), .box_y(d4_box_y), .update(d4_update), .bounce(d4_bounce),
    .state_dbg(d4_state)
  );

  int errors = 0;
  int checks = 0;

  // Reference model, one slot per instance: index 0 -> FRAME_DIV=1, index 1 -> FRAME_DIV=4.
  int m_div[2] = '{1, 4};
  int m_x[2], m_y[2], m_dx[2], m_dy[2], m_b[2];
  int m_pend[2], m_px[2], m_py[2], m_cnt[2];
  bit m_step[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_x[k] = 250; m_y[k] = 200; m_dx[k] = 1; m_dy[k] = 1; m_b[k] = 0;
      m_pend[k] = 0; m_px[k] = 0; m_py[k] = 0; m_cnt[k] = 0; m_step[k] = 0;
    end
  endtask

  task automatic model_load(input int lx, input int ly);
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1; m_px[k] = lx; m_py[k] = ly;
    end
  endtask

  // dir: 1 = moving toward the far wall, 0 = toward 0.
  task automatic move(input int pos, input int dir, input int sp, input int lim,
                      output int npos, output int ndir, output int hit);
    npos = pos; ndir = dir; hit = 0;
    if (sp != 0) begin
      if (dir == 1) begin
        if (pos + sp >= lim) begin npos = lim; ndir = 0; hit = 1; end
        else npos = pos + sp;
      end else begin
        if (pos <= sp) begin npos = 0; ndir = 1; hit = 1; end
        else npos = pos - sp;
      end
    end
  endtask

  task automatic model_frame();
    int nx, ndx, hx, ny, ndy, hy;
    for (int k = 0; k < 2; k++) begin
      m_step[k] = 0;
      m_cnt[k]++;
      if (m_cnt[k] == m_div[k]) begin
        m_cnt[k] = 0;
        if (enable || m_pend[k] != 0) begin
          m_step[k] = 1;
          if (m_pend[k] != 0) begin
            m_x[k] = (m_px[k] > XMAX) ? XMAX : m_px[k];
            m_y[k] = (m_py[k] > YMAX) ? YMAX : m_py[k];
            m_b[k] = 0;
            m_pend[k] = 0;
          end else begin
            move(m_x[k], m_dx[k], int'(speed_x), XMAX, nx, ndx, hx);
            move(m_y[k], m_dy[k], int'(speed_y), YMAX, ny, ndy, hy);
            m_x[k] = nx; m_dx[k] = ndx; m_y[k] = ny; m_dy[k] = ndy;
            m_b[k] = hy * 2 + hx;
          end
        end
      end
    end
  endtask

  task automatic check_pos();
    chk("d1_box_x", d1_box_x, m_x[0]);
    chk("d1_box_y", d1_box_y, m_y[0]);
    chk("d1_bounce", d1_bounce, m_b[0]);
    chk("d4_box_x", d4_box_x, m_x[1]);
    chk("d4_box_y", d4_box_y, m_y[1]);
    chk("d4_bounce", d4_bounce, m_b[1]);
  endtask

  task automatic do_load(input int lx, input int ly);
    load = 1'b1; load_x = 10'(lx); load_y = 10'(ly);
    @(posedge CLOCK_50); #1;
    load = 1'b0;
    model_load(lx, ly);
  endtask

  // One vs pulse of `hold` cycles; update must pulse exactly after edge 6 when a step is due.
  // With load_commit, a load is sampled on edge 6, the cycle dut1 sits in COMMIT.
  task automatic frame(input int hold, input bit load_commit, input int lx, input int ly);
    model_frame();
    vs = 1'b1;
    for (int c = 0; c < hold + 14; c++) begin
      @(posedge CLOCK_50); #1;
      if (c == hold - 1) vs = 1'b0;
      if (load_commit && c == 5) begin load = 1'b1; load_x = 10'(lx); load_y = 10'(ly); end
      if (load_commit && c == 6) load = 1'b0;
      chk("d1_update", d1_update, (m_step[0] && c == 6));
      chk("d4_update", d4_update, (m_step[1] && c == 6));
      if (m_step[0] && c == 3) chk("d1_state_step_x", d1_state, 2'd1);
    end
    if (load_commit) model_load(lx, ly);
    check_pos();
  endtask

  initial begin
    RESET_N = 1'b1;
    #5 RESET_N = 1'b0;
    model_reset();
    @(posedge CLOCK_50); #1;
    chk("rst_box_x", d1_box_x, 250);
    chk("rst_box_y", d1_box_y, 200);
    chk("rst_update", d1_update, 0);
    chk("rst_bounce", d1_bounce, 0);
    chk("rst_state", d1_state, 0);
    RESET_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLOCK_50); #1;
      chk("idle_no_update1", d1_update, 0);
      chk("idle_no_update4", d4_update, 0);
    end

    // Plain stepping
    enable = 1'b1; speed_x = 4'd3; speed_y = 4'd2;
    for (int i = 0; i < 5; i++) frame(1 + i * 7, 1'b0, 0, 0);
    chk("step5_x", d1_box_x, 265);
    chk("step5_y", d1_box_y, 210);

    // Right wall bounce
    speed_x = 4'd7; speed_y = 4'd0;
    do_load(760, 210);
    frame(2, 1'b0, 0, 0);
    chk("load760_x", d1_box_x, 760);
    frame(2, 1'b0, 0, 0);
    chk("wall_x_767", d1_box_x, 767);
    frame(2, 1'b0, 0, 0);
    chk("wall_x_768", d1_box_x, 768);
    chk("wall_bounce", d1_bounce, 2'b01);
    speed_x = 4'd3;
    frame(2, 1'b0, 0, 0);
    chk("wall_x_765", d1_box_x, 765);

    // Left wall: direction stays '-' across a load
    do_load(2, 210);
    frame(3, 1'b0, 0, 0);
    frame(3, 1'b0, 0, 0);
    chk("left_x_0", d1_box_x, 0);
    chk("left_bounce", d1_bounce, 2'b01);
    frame(3, 1'b0, 0, 0);
    chk("left_x_3", d1_box_x, 3);

    // Load with motion disabled, clamped to the limits
    enable = 1'b0;
    do_load(900, 590);
    frame(4, 1'b0, 0, 0);
    chk("clamp_x", d1_box_x, 768);
    chk("clamp_y", d1_box_y, 568);
    frame(4, 1'b0, 0, 0);

    // Load landing in the COMMIT cycle is kept for the next step
    enable = 1'b1; speed_x = 4'd1; speed_y = 4'd1;
    frame(2, 1'b1, 100, 50);
    enable = 1'b0;
    frame(2, 1'b0, 0, 0);
    chk("commit_load_x", d1_box_x, 100);
    chk("commit_load_y", d1_box_y, 50);

    // Randomized frames
    for (int i = 0; i < 30; i++) begin
      enable  = 1'($urandom_range(0, 3) != 0);
      speed_x = 4'($urandom_range(0, 15));
      speed_y = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 1023), $urandom_range(0, 1023));
      if ($urandom_range(0, 5) == 0)
        frame($urandom_range(1, 25), 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023));
      else
        frame($urandom_range(1, 25), 1'b0, 0, 0);
    end

    // Reset between STEP_Y and COMMIT aborts the step
    enable = 1'b1; speed_x = 4'd5; speed_y = 4'd5;
    vs = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLOCK_50); #1;
      chk("pre_abort_update", d1_update, 0);
    end
    chk("abort_in_step_y", d1_state, 2'd2);
    RESET_N = 1'b0;
    vs = 1'b0;
    #1;
    chk("abort_box_x", d1_box_x, 250);
    chk("abort_box_y", d1_box_y, 200);
    chk("abort_update", d1_update, 0);
    chk("abort_bounce", d1_bounce, 0);
    chk("abort_state", d1_state, 0);
    chk("abort4_box_x", d4_box_x, 250);
    model_reset();
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    RESET_N = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLOCK_50); #1;
      chk("post_rst_no_update1", d1_update, 0);
      chk("post_rst_no_update4", d4_update, 0);
    end
    for (int i = 0; i < 4; i++) frame(3, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/box_motion_ctrl.md
# box_motion_ctrl

Frame-synchronous motion scheduler for the moving box on the 800x600 VGA output. It watches the `vs` sync output of `vga_display`, divides frames, and steps a box position with wall bounce. It publishes the new position only during the vertical sync pulse, so the line scanner never sees a mid-frame change. It also accepts an asynchronous position-load request from a host and applies it at the next frame boundary.

## Interface
- `SCREEN_WIDTH`, default 800: horizontal extent in pixels.
- `SCREEN_HEIGHT`, default 600: vertical extent in pixels.
- `BOX_W`, default 32: box width in pixels.
- `BOX_H`, default 32: box height in pixels.
- `X_INIT`, default 250: reset x position.
- `Y_INIT`, default 200: reset y position.
- `FRAME_DIV`, default 1: frames per motion step, range 1..255.
- `VS_ACTIVE_HIGH`, default 1: polarity of `vs`.
- `CLOCK_50` input 1: sole clock, rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `vs` input 1: vertical sync from `vga_display`. Asynchronous to this block's logic view.
- `enable` input 1: motion enable, level.
- `speed_x` input 4: pixels per step in x.
- `speed_y` input 4: pixels per step in y.
- `load` input 1: one-cycle pulse requesting a position load.
- `load_x` input 10: load value for x, sampled with `load`.
- `load_y` input 10: load value for y, sampled with `load`.
- `box_x` output 10: committed top-left x.
- `box_y` output 10: committed top-left y.
- `update` output 1: one-cycle pulse when `box_x`/`box_y` are committed.
- `bounce` output 2: {y,x} wall-hit flags for the committed step. Valid with `update`, held until the next commit.

## Operation
- **Sync detect:** `vs` passes through a 2-flop synchronizer and a third delay flop. The frame edge is the asserted-going transition after polarity correction.
- **Frame divider:** an 8-bit counter advances on each frame edge. When it reaches FRAME_DIV-1 it wraps to 0 and raises a step request.
  - The divider runs regardless of `enable`.
- **Load capture:**
  - On `load`, latch `load_x`/`load_y` into a pending register and set `pend`.
  - A later `load` before commit overwrites the pending values.
- **FSM states:** IDLE, STEP_X, STEP_Y, COMMIT.
  - IDLE -> STEP_X on a step request when (`enable` | `pend`); otherwise remain in IDLE.
  - Entering STEP_X latches `speed_x`/`speed_y`.
  - STEP_X -> STEP_Y -> COMMIT -> IDLE, unconditionally, one cycle each.
  - Frame edges arriving outside IDLE are ignored. The divider still counts them.
- **Motion arithmetic (`pend`=0):** 11-bit, unsigned. Limits are XMAX = SCREEN_WIDTH-BOX_W and YMAX = SCREEN_HEIGHT-BOX_H.
  - Direction +: if x+speed >= XMAX, then x=XMAX, dir becomes -, x-bounce flag=1. Otherwise x += speed.
  - Direction -: if x <= speed, then x=0, dir becomes +, flag=1. Otherwise x -= speed.
  - Y is the same using YMAX.
  - Speed 0: no movement, no flip, flag=0.
- **Load (`pend`=1):** load has priority over motion for that step.
  - x = min(load_x, XMAX), y = min(load_y, YMAX).
  - Directions are unchanged, `bounce`=0, and `pend` clears in COMMIT.
  - A `load` arriving in the same cycle as COMMIT sets `pend` again with the new values and is not lost.
- **COMMIT:** copy the shadow x/y into `box_x`/`box_y`, set `bounce`, pulse `update`.

## Timing
- **Reset values:**
  - `box_x`=X_INIT, `box_y`=Y_INIT.
  - `update`=0, `bounce`=0.
  - Directions +/+, divider 0, `pend`=0, state IDLE, synchronizer flops deasserted.
- **Latency:** edge 0 is the first `CLOCK_50` edge sampling `vs` asserted. With FRAME_DIV=1:
  - state=STEP_X after edge 3.
  - `box_x`/`box_y`/`bounce` change and `update`=1 after edge 6.
  - `update` returns to 0 after edge 7.
- Outputs change at no other time.
- `RESET_N` low mid-sequence aborts immediately to the reset values. No `update` pulse follows reset release until a new frame edge arrives.
- `vs` held asserted for many cycles generates only one frame edge.

## Test plan
- **Reset:** RESET_N low with outputs X, then release -> box_x=250, box_y=200, update=0, and no update without `vs` activity.
- **Stepping:** enable=1, speed_x=3, speed_y=2, five `vs` pulses -> update pulses exactly once per pulse at edge 6. Final box_x=265, box_y=210.
- **Bounce:** load x=760; next frame x=767 (XMAX=768, 767<768); next frame x=768 with bounce=01; next frame x=765.
- **Left wall:** direction -, x=2, speed_x=3 -> x=0, bounce[0]=1, direction flips to +.
- **Load:** load 900/590 with enable=0 -> next frame box_x=768, box_y=568, update=1. A following frame with enable=0 -> no update.
- **Divider and reset:** FRAME_DIV=4 -> one update per 4 `vs` pulses. Assert RESET_N low between STEP_Y and COMMIT -> no update, outputs return to 250/200.
